// File: rtl/bcd2_down_pkg.sv
// bcd2_down_pkg: shared BCD digit constants and the per-digit load clamp
// BCD_W    : bits per BCD digit
// BCD_MAX  : largest legal digit (9)
// BCD_ZERO : digit value zero
package bcd2_down_pkg;
    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction
endpackage

// File: rtl/bcd1_down.sv
// bcd1_down: one BCD down-counting digit with synchronous load
// clk      : rising-edge clock
// reset    : asynchronous active-low reset, digit takes RST
// en       : decrement this digit on the next edge
// ld       : load ld_digit on the next edge (overrides en)
// ld_digit : already-clamped digit to load
// digit    : registered digit value
// bout     : borrow out, en while the digit sits at zero
module bcd1_down
    import bcd2_down_pkg::*;
#(
    parameter logic [3:0] RST = BCD_ZERO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       ld,
    input  logic [3:0] ld_digit,
    output logic [3:0] digit,
    output logic       bout
);
    logic [3:0] digit_d, digit_q;

    always_comb
        digit_d = ld ? ld_digit :
                  en ? ((digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1) : digit_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) digit_q <= RST;
        else        digit_q <= digit_d;

    assign digit = digit_q;
    assign bout  = en & (digit_q == BCD_ZERO);
endmodule

// File: rtl/bcd2_down.sv
// bcd2_down: loadable multi-digit BCD down-counter with wrap/stop underflow
// clk      : rising-edge clock
// reset    : asynchronous active-low reset
// x        : decrement enable
// load     : synchronous load strobe (priority over x)
// load_val : packed BCD load value, nibbles above 9 clamp to 9
// wrap     : 1 = 0 wraps to all-9s with borrow, 0 = stop at 0
// bcd_out  : registered packed BCD count, digit 0 in [3:0]
// zero     : bcd_out == 0
// borrow   : one-cycle pulse after a wrap-around underflow
module bcd2_down
    import bcd2_down_pkg::*;
#(
    parameter int                      DIGITS    = 2,
    parameter logic [BCD_W*DIGITS-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      x,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
    input  logic                      wrap,
    output logic [BCD_W*DIGITS-1:0]   bcd_out,
    output logic                      zero,
    output logic                      borrow
);
    localparam int W = BCD_W * DIGITS;

    logic [W-1:0] count;
    logic         borrow_d, borrow_q;

    assign zero = (count == '0);

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic en_i, bout_i;
        // Stop mode freezes the whole chain at zero, so no digit ever rolls to 9.
        if (i == 0) begin : g_first
            assign en_i = x & ~load & ~(zero & ~wrap);
        end else begin : g_rest
            assign en_i = g_dig[i-1].en_i & g_dig[i-1].bout_i;
        end
        bcd1_down #(.RST(RESET_VAL[BCD_W*i +: BCD_W])) u_dig (
            .clk      (clk),
            .reset    (reset),
            .en       (en_i),
            .ld       (load),
            .ld_digit (bcd_clamp(load_val[BCD_W*i +: BCD_W])),
            .digit    (count[BCD_W*i +: BCD_W]),
            .bout     (bout_i)
        );
    end

    // A borrow out of the top digit only happens when every digit was 0 and wrapped.
    always_comb borrow_d = g_dig[DIGITS-1].bout_i;

    always_ff @(posedge clk or negedge reset)
        if (!reset) borrow_q <= 1'b0;
        else        borrow_q <= borrow_d;

    assign bcd_out = count;
    assign borrow  = borrow_q;
endmodule

// File: tb/tb_bcd2_down.sv
// tb_bcd2_down: directed and randomized checks of bcd2_down against a decimal model
module tb_bcd2_down;
    localparam int             DIGITS    = 2;
    localparam int             W         = 4 * DIGITS;
    localparam logic [W-1:0]   RESET_VAL = '0;
    localparam int             MOD       = 10 ** DIGITS;

    logic         clk = 0, reset = 1, x = 0, load = 0, wrap = 0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] bcd_out;
    logic         zero, borrow;

    int   total = 0, bad = 0;
    int   m_cnt = 0;
    logic m_borrow = 0;
    bit   live = 0;
    int   pulses;

    always #5 clk = ~clk;

    bcd2_down #(.DIGITS(DIGITS), .RESET_VAL(RESET_VAL)) dut (
        .clk(clk), .reset(reset), .x(x), .load(load), .load_val(load_val),
        .wrap(wrap), .bcd_out(bcd_out), .zero(zero), .borrow(borrow)
    );

    function automatic int dec_of(input logic [W-1:0] b);
        int v = 0, p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v += ((b[4*i +: 4] > 4'd9) ? 9 : int'(b[4*i +: 4])) * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] bcd_of(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v /= 10;
        end
        return r;
    endfunction

    function automatic logic legal(input logic [W-1:0] b);
        for (int i = 0; i < DIGITS; i++)
            if (!(b[4*i +: 4] <= 4'd9)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Decimal model: the count is a plain integer in [0, 10^DIGITS).
    always @(posedge clk or negedge reset)
        if (!reset) begin
            m_cnt    <= dec_of(RESET_VAL);
            m_borrow <= 1'b0;
        end else if (load) begin
            m_cnt    <= dec_of(load_val);
            m_borrow <= 1'b0;
        end else if (x && m_cnt > 0) begin
            m_cnt    <= m_cnt - 1;
            m_borrow <= 1'b0;
        end else if (x && wrap) begin
            m_cnt    <= MOD - 1;
            m_borrow <= 1'b1;
        end else
            m_borrow <= 1'b0;

    always @(negedge clk)
        if (live) begin
            chk("model_count", bcd_out, bcd_of(m_cnt));
            chk("model_zero", W'(zero), W'(m_cnt == 0));
            chk("model_borrow", W'(borrow), W'(m_borrow));
            chk("nibbles_legal", W'(legal(bcd_out)), W'(1));
        end

    initial begin
        if (!legal(RESET_VAL)) begin
            $display("FAIL reset_val_legal: RESET_VAL %h has a nibble above 9", RESET_VAL);
            $fatal(1);
        end
        #1 reset = 0;
        live = 1;
        #1;
        chk("reset_count", bcd_out, 8'h00);
        chk("reset_zero", W'(zero), W'(1));
        chk("reset_borrow", W'(borrow), W'(0));
        step();
        reset = 1;

        load = 1; load_val = 8'h10; step();
        load = 0; x = 1; step();
        chk("dec_10_09", bcd_out, 8'h09);
        chk("dec_zero_lo", W'(zero), W'(0));
        step();
        chk("dec_09_08", bcd_out, 8'h08);
        chk("dec_borrow_lo", W'(borrow), W'(0));

        load = 1; load_val = 8'hAF; x = 1; step();
        chk("clamp_load", bcd_out, 8'h99);
        load = 0; step();
        chk("after_clamp", bcd_out, 8'h98);

        load = 1; load_val = 8'h01; wrap = 1; x = 0; step();
        load = 0; x = 1; step();
        chk("wrap_01_00", bcd_out, 8'h00);
        chk("wrap_zero", W'(zero), W'(1));
        step();
        chk("wrap_99", bcd_out, 8'h99);
        chk("wrap_borrow", W'(borrow), W'(1));
        step();
        chk("wrap_borrow_clear", W'(borrow), W'(0));
        chk("wrap_98", bcd_out, 8'h98);

        load = 1; load_val = 8'h00; step();
        load = 0; step();
        chk("pre_reset_borrow", W'(borrow), W'(1));
        reset = 0;
        #1;
        chk("async_reset_count", bcd_out, 8'h00);
        chk("async_reset_zero", W'(zero), W'(1));
        chk("async_reset_borrow", W'(borrow), W'(0));
        step();
        reset = 1;

        wrap = 0; x = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stop_count", bcd_out, 8'h00);
            chk("stop_borrow", W'(borrow), W'(0));
        end

        reset = 0; step(); reset = 1;
        wrap = 1; x = 1; pulses = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (borrow) pulses++;
        end
        chk("full_period_pulses", W'(pulses), W'(2));

        for (int i = 0; i < 3000; i++) begin
            load     = ($urandom % 8) == 0;
            load_val = W'($urandom);
            x        = ($urandom % 4) != 0;
            wrap     = ($urandom % 3) != 0;
            if ($urandom % 200 == 0) begin
                reset = 0;
                step();
                reset = 1;
            end else
                step();
        end

        live = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
